// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, pixel mode enum and colour expansion helpers
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  typedef enum logic {PIX_GREY, PIX_RGB332} pix_mode_e;
  function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
  endfunction
  function automatic logic [23:0] bar_colour(input logic [2:0] i);
    return {{8{~i[1]}}, {8{~i[2]}}, {8{~i[0]}}};
  endfunction
endpackage

// File: rtl/vga_timing_core.sv
// vga_timing_core: pixel clock-enable divider, fetch counters and stage-0 timing decodes
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int DIV      = 2,
  parameter int CW       = 10,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_en,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          act,
  output logic          hs,
  output logic          vs
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  logic [DW-1:0] div_cnt, div_nxt;
  logic          h_wrap, v_wrap;
  // next divider count and wrap detection of the fetch counters
  always_comb begin
    div_nxt = (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
    h_wrap  = hcnt == CW'(H_TOTAL - 1);
    v_wrap  = vcnt == CW'(V_TOTAL - 1);
  end
  // pix_en is registered so it is low in reset even when DIV is 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      div_cnt <= div_nxt;
      pix_en  <= div_nxt == DW'(DIV - 1);
      if (pix_en) begin
        hcnt <= h_wrap ? '0 : hcnt + 1'b1;
        if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      end
    end
  end
  // active area and sync windows for the current fetch position
  always_comb begin
    act = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
    hs  = (hcnt >= CW'(H_ACTIVE + H_FP)) && (hcnt < CW'(H_ACTIVE + H_FP + H_SYNC));
    vs  = (vcnt >= CW'(V_ACTIVE + V_FP)) && (vcnt < CW'(V_ACTIVE + V_FP + V_SYNC));
  end
endmodule

// File: rtl/vga_display_engine.sv
// vga_display_engine: VGA timing, sync/blank realignment and greyscale/RGB332 expansion; VGA_TEST_PATTERN_EN adds colour bars
module vga_display_engine
  import vga_pkg::*;
#(
  parameter int DIV      = 2,
  parameter int CW       = 10,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIX_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic          test_mode,
`endif
  input  logic [7:0]    video_data,
  output logic          pix_en,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          sync_b,
  output logic          blank_b,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          frame_start
);
  logic        act, hs, vs, seen;
  logic [23:0] pix_rgb;
  vga_timing_core #(
    .DIV(DIV), .CW(CW),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_core (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
    .act(act), .hs(hs), .vs(vs)
  );
  assign sync_b = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
  logic [2:0] bar;
  // bar index only matters inside the active area, so truncation is harmless
  always_comb begin
    bar     = 3'(hcnt / CW'(BAR_W));
    pix_rgb = test_mode ? bar_colour(bar)
            : (PIX_MODE == int'(PIX_RGB332)) ? rgb332_expand(video_data) : {3{video_data}};
  end
`else
  // colour expansion of the returned frame-buffer pixel
  always_comb pix_rgb = (PIX_MODE == int'(PIX_RGB332)) ? rgb332_expand(video_data) : {3{video_data}};
`endif
  // stage 1: align sync, blank and colour with the pixel returned one slot after its fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync       <= ~1'(H_POL);
      vsync       <= ~1'(V_POL);
      blank_b     <= 1'b0;
      {R, G, B}   <= '0;
      frame_start <= 1'b0;
      seen        <= 1'b0;
    end else begin
      frame_start <= pix_en && seen && hcnt == '0 && vcnt == '0;
      if (pix_en) begin
        seen      <= 1'b1;
        blank_b   <= act;
        hsync     <= hs ? 1'(H_POL) : ~1'(H_POL);
        vsync     <= vs ? 1'(V_POL) : ~1'(V_POL);
        {R, G, B} <= act ? pix_rgb : '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_display_engine.sv
// tb_vga_display_engine: directed checks of timing, sync widths, colour expansion and frame_start on a reduced raster
module tb_vga_display_engine;
  localparam int CW = 10;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  logic          clk = 1'b0, reset = 1'b0, test_mode = 1'b0;
  logic [7:0]    video_data = 8'h00;
  logic          pix_en, hsync, vsync, sync_b, blank_b, frame_start;
  logic [CW-1:0] hcnt, vcnt;
  logic [7:0]    r, g, b;
  logic          pix_en2, hsync2, vsync2, sync_b2, blank_b2, frame_start2;
  logic [CW-1:0] hcnt2, vcnt2;
  logic [7:0]    r2, g2, b2;
  int            tests = 0, fails = 0;
  always #5 clk = ~clk;
  vga_display_engine #(
    .DIV(2), .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(0), .V_POL(0), .PIX_MODE(0)
  ) u_grey (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .video_data(video_data), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .R(r), .G(g), .B(b), .frame_start(frame_start)
  );
  vga_display_engine #(
    .DIV(2), .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(0), .V_POL(0), .PIX_MODE(1)
  ) u_332 (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .video_data(video_data), .pix_en(pix_en2), .hcnt(hcnt2), .vcnt(vcnt2),
    .hsync(hsync2), .vsync(vsync2), .sync_b(sync_b2), .blank_b(blank_b2),
    .R(r2), .G(g2), .B(b2), .frame_start(frame_start2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(hcnt == CW'(h) && vcnt == CW'(v)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("goto_%0d_%0d", h, v), 32'(hcnt == CW'(h) && vcnt == CW'(v)), 1);
  endtask
  task automatic step_pix();
    int n = 0;
    while (!pix_en && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!pix_en) check("pix_en_timeout", pix_en, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_en", pix_en, 0);
    check("rst_hcnt", hcnt, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_blank", blank_b, 0);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_sync_b", sync_b, 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(pix_en);
    end
    check("pix_en_rate", n, 10);
    goto(31, 0);
    step_pix();
    check("hwrap_hcnt", hcnt, 0);
    check("hwrap_vcnt", vcnt, 1);
    goto(20, 1);
    check("hsync_pre", hsync, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step_pix();
      if (hsync) break;
      n++;
    end
    check("hsync_width", n, 6);
    goto(0, 10);
    check("vsync_pre", vsync, 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step_pix();
      if (vsync) break;
      n++;
    end
    check("vsync_width_pix", n, 64);
    goto(31, 14);
    step_pix();
    check("fwrap_hv", {hcnt, vcnt}, 0);
    goto(5, 3);
    video_data = 8'h5A;
    step_pix();
    check("grey_rgb", {r, g, b}, 24'h5A5A5A);
    check("grey_blank", blank_b, 1);
    check("rgb332_5a", {r2, g2, b2}, 24'h49DBAA);
    goto(18, 3);
    step_pix();
    check("hblank_rgb", {r, g, b}, 0);
    check("hblank_blank", blank_b, 0);
    check("hblank_rgb332", {r2, g2, b2}, 0);
    goto(6, 4);
    video_data = 8'b101_011_10;
    step_pix();
    check("grey_ae", {r, g, b}, 24'hAEAEAE);
    check("rgb332_ae", {r2, g2, b2}, 24'hB66DAA);
    goto(5, 9);
    video_data = 8'h5A;
    step_pix();
    check("vblank_rgb", {r, g, b}, 0);
    check("vblank_blank", blank_b, 0);
`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    goto(0, 5);
    step_pix();
    check("bar_white", {r, g, b}, 24'hFFFFFF);
    goto(2, 5);
    step_pix();
    check("bar_yellow", {r, g, b}, 24'hFFFF00);
    goto(4, 5);
    step_pix();
    check("bar_cyan", {r2, g2, b2}, 24'h00FFFF);
    goto(14, 5);
    step_pix();
    check("bar_black", {r, g, b}, 0);
    check("bar_black_blank", blank_b, 1);
    test_mode = 1'b0;
`endif
    goto(12, 6);
    video_data = 8'hFF;
    step_pix();
    check("pre_rst_rgb", {r, g, b}, 24'hFFFFFF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_hv", {hcnt, vcnt}, 0);
    check("midrst_blank", blank_b, 0);
    check("midrst_rgb", {r, g, b}, 0);
    check("midrst_pix_en", pix_en, 0);
    check("midrst_hsync", hsync, 1);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (frame_start) break;
      n += int'(pix_en);
    end
    check("frame_start_seen", frame_start, 1);
    check("frame_start_delay", n, 481);
    check("frame_start_blank", blank_b, 1);
    check("frame_start_hcnt", hcnt, 1);
    @(negedge clk);
    check("frame_start_once", frame_start, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
